alu_op_sequencer: RTL and testbench

- Sequences the shared ALU datapath from a byte-wide command stream, since pin-limited top-level IO cannot present opcode and both operands at once.
- Collects command, operand A and operand B over an 8-bit valid/ready input, then drives the ALU for a fixed number of cycles.
- Captures result and flags, and presents them on a valid/ready output.
- Sits between the top-level IO mapping and the ALU core inside the tt_um top.

---
 rtl/alu_op_sequencer_if.sv | 24 ++
 rtl/alu_op_sequencer.sv | 138 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Byte-wide command stream in, captured ALU result out, between the IO mapping and the ALU sequencer.
// Valid/ready: a transfer occurs on the rising clk edge where valid && ready are both high; the
// producer holds data stable while valid is high and not yet accepted; ready may depend on state only.
interface alu_op_sequencer_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] res_data;
   logic [4:0]       res_flags;
   logic             res_valid;
   logic             res_ready;

   modport master (
      output in_data, in_valid, res_ready,
      input  in_ready, res_data, res_flags, res_valid
   );

   modport slave (
      input  in_data, in_valid, res_ready,
      output in_ready, res_data, res_flags, res_valid
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// Collects opcode and operands byte by byte, drives the shared ALU for EXEC_CYCLES cycles,
// then holds the captured result and flags until the consumer takes them.
module alu_op_sequencer #(
   parameter int WIDTH       = 8,
   parameter int NUM_OPS     = 12,
   parameter int EXEC_CYCLES = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   alu_op_sequencer_if.slave   bus,
   output logic [WIDTH-1:0]    alu_a,
   output logic [WIDTH-1:0]    alu_b,
   output logic [3:0]          alu_op,
   output logic                alu_go,
   input  logic [WIDTH-1:0]    alu_result,
   input  logic [3:0]          alu_flags,
   output logic                busy,
   output logic [7:0]          op_count,
   output logic [2:0]          dbg_state
);

   localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_CMD    = 3'd0,
      S_GET_A  = 3'd1,
      S_GET_B  = 3'd2,
      S_EXEC   = 3'd3,
      S_RESULT = 3'd4
   } state_t;

   state_t          state;
   state_t          next_state;
   logic [CW-1:0]   exec_cnt;
   logic [3:0]      pend_op;
   logic [WIDTH-1:0] last_result;

   logic            accept;
   logic [3:0]      cmd_op;
   logic            cmd_chain;
   logic            cmd_legal;
   logic            exec_last;

   assign cmd_op    = bus.in_data[3:0];
   assign cmd_chain = bus.in_data[4];
   assign cmd_legal = ({1'b0, cmd_op} < 5'(NUM_OPS));
   assign exec_last = (exec_cnt == CW'(EXEC_CYCLES - 1));

   assign bus.in_ready  = (state == S_CMD) || (state == S_GET_A) || (state == S_GET_B);
   assign bus.res_valid = (state == S_RESULT);
   assign accept        = bus.in_valid && bus.in_ready;
   assign busy          = (state != S_CMD);
   assign dbg_state     = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_CMD;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_CMD: begin
            if (accept) begin
               if (!cmd_legal)     next_state = S_RESULT;
               else if (cmd_chain) next_state = S_GET_B;
               else                next_state = S_GET_A;
            end
         end
         S_GET_A:  if (accept) next_state = S_GET_B;
         S_GET_B:  if (accept) next_state = S_EXEC;
         S_EXEC:   if (exec_last) next_state = S_RESULT;
         S_RESULT: if (bus.res_ready) next_state = S_CMD;
         default:  next_state = S_CMD;
      endcase
      // Abort overrides everything, including a result handshake in the same cycle.
      if (clear) next_state = S_CMD;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_a         <= '0;
         alu_b         <= '0;
         alu_op        <= '0;
         alu_go        <= 1'b0;
         exec_cnt      <= '0;
         pend_op       <= '0;
         last_result   <= '0;
         bus.res_data  <= '0;
         bus.res_flags <= '0;
         op_count      <= '0;
      end else begin
         alu_go <= 1'b0;
         if (clear) begin
            last_result <= '0;
         end else begin
            case (state)
               S_CMD: begin
                  if (accept) begin
                     pend_op <= cmd_op;
                     if (!cmd_legal) begin
                        bus.res_data  <= '0;
                        bus.res_flags <= 5'b10000;
                     end else if (cmd_chain) begin
                        alu_a <= last_result;
                     end
                  end
               end
               S_GET_A: begin
                  if (accept) alu_a <= bus.in_data;
               end
               S_GET_B: begin
                  if (accept) begin
                     alu_b    <= bus.in_data;
                     alu_op   <= pend_op;
                     exec_cnt <= '0;
                     alu_go   <= 1'b1;
                  end
               end
               S_EXEC: begin
                  exec_cnt <= exec_cnt + CW'(1);
                  if (exec_last) begin
                     bus.res_data  <= alu_result;
                     bus.res_flags <= {1'b0, alu_flags};
                     last_result   <= alu_result;
                  end
               end
               S_RESULT: begin
                  if (bus.res_ready) op_count <= op_count + 8'd1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed and randomized checks of the command sequencer against a transaction-level model
// with a stub ALU; expected results travel through a queue to the result handshake.
module tb_alu_op_sequencer;
   localparam int W    = 8;
   localparam int NOPS = 12;
   localparam int EXEC = 3;
   localparam int SW   = 13;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clear = 1'b0;

   alu_op_sequencer_if #(.WIDTH(W)) bus ();

   logic [W-1:0] alu_a, alu_b, alu_result;
   logic [3:0]   alu_op, alu_flags;
   logic         alu_go, busy;
   logic [7:0]   op_count;
   logic [2:0]   dbg_state;

   int total = 0;
   int bad   = 0;
   logic [SW-1:0] exp_q[$];
   logic [W-1:0]  m_last  = '0;
   logic [7:0]    m_count = '0;

   always #5 clk = ~clk;

   alu_op_sequencer #(.WIDTH(W), .NUM_OPS(NOPS), .EXEC_CYCLES(EXEC)) dut (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear),
      .bus        (bus),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_go     (alu_go),
      .alu_result (alu_result),
      .alu_flags  (alu_flags),
      .busy       (busy),
      .op_count   (op_count),
      .dbg_state  (dbg_state)
   );

   // Stub ALU: returns {V,N,C,Z, result}.
   function automatic logic [W+3:0] alu_model(input logic [3:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
      logic [W:0]   wide;
      logic [W-1:0] r;
      logic         v;
      wide = {1'b0, a} + {1'b0, b};
      case (op)
         4'd0:    r = wide[W-1:0];
         4'd1:    r = a - b;
         4'd2:    r = a & b;
         4'd3:    r = a | b;
         4'd4:    r = a ^ b;
         4'd5:    r = a << b[2:0];
         4'd6:    r = a >> b[2:0];
         default: r = a + b + {4'b0, op};
      endcase
      v = (op == 4'd0) && (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      return {v, r[W-1], (op == 4'd0) & wide[W], (r == '0), r};
   endfunction

   assign {alu_flags, alu_result} = alu_model(alu_op, alu_a, alu_b);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      @(negedge clk);
      while (bus.in_ready !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) begin
         total++;
         bad++;
         $display("FAIL send_timeout observed=in_ready_low expected=in_ready_high");
      end
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
   endtask

   task automatic take_result(input int hold);
      int n;
      logic [SW-1:0] e;
      n = 0;
      while (bus.res_valid !== 1'b1 && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 40) begin
         total++;
         bad++;
         $display("FAIL result_timeout observed=res_valid_low expected=res_valid_high");
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check("res_data", bus.res_data, e[7:0]);
      check("res_flags", bus.res_flags, e[12:8]);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check("bp_valid", bus.res_valid, 1);
         check("bp_stable", {bus.res_flags, bus.res_data}, e);
         check("bp_in_ready", bus.in_ready, 0);
      end
      @(negedge clk);
      check("hs_no_bypass", bus.in_ready, 0);
      bus.res_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.res_ready = 1'b0;
      m_count++;
      check("op_count", op_count, m_count);
      check("in_ready_after_hs", bus.in_ready, 1);
      check("valid_drop_after_hs", bus.res_valid, 0);
   endtask

   task automatic do_op(input logic [7:0] cmd, input logic [7:0] a, input logic [7:0] b,
                        input int hold, input bit take);
      logic [3:0]   op;
      logic [W-1:0] ea;
      logic [W+3:0] r;
      op = cmd[3:0];
      send_byte(cmd);
      if (int'(op) >= NOPS) begin
         exp_q.push_back({5'b10000, 8'h00});
         check("illegal_to_result", bus.res_valid, 1);
         check("illegal_no_go", alu_go, 0);
         check("illegal_in_ready", bus.in_ready, 0);
      end else begin
         if (cmd[4]) begin
            ea = m_last;
            check("chain_alu_a", alu_a, m_last);
         end else begin
            ea = a;
            send_byte(a);
         end
         send_byte(b);
         r = alu_model(op, ea, b);
         check("go_after_b", alu_go, 1);
         check("alu_a", alu_a, ea);
         check("alu_b", alu_b, b);
         check("alu_op", alu_op, op);
         for (int i = 1; i < EXEC; i++) begin
            @(posedge clk);
            #1;
            check("exec_valid_low", bus.res_valid, 0);
            check("go_single_pulse", alu_go, 0);
         end
         @(posedge clk);
         #1;
         check("valid_latency", bus.res_valid, 1);
         exp_q.push_back({1'b0, r});
         m_last = r[W-1:0];
      end
      if (take) take_result(hold);
   endtask

   task automatic rand_op();
      do_op(8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 3), 1'b1);
   endtask

   initial begin
      bus.in_data   = '0;
      bus.in_valid  = 1'b0;
      bus.res_ready = 1'b0;
      #12;
      check("rst_busy", busy, 0);
      check("rst_res_valid", bus.res_valid, 0);
      check("rst_op_count", op_count, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("rst_in_ready", bus.in_ready, 1);

      // Basic add, chained add, illegal opcode, backpressure.
      do_op(8'h00, 8'h25, 8'h13, 0, 1'b1);
      do_op(8'h10, 8'h00, 8'h02, 0, 1'b1);
      check("chain_value", m_last, 8'h3A);
      do_op(8'h0F, 8'h00, 8'h00, 0, 1'b1);
      check("illegal_keeps_last", m_last, 8'h3A);
      do_op(8'h01, 8'h90, 8'h11, 5, 1'b1);

      // clear in S_GET_B with a simultaneous byte offered.
      send_byte(8'h02);
      send_byte(8'h55);
      @(negedge clk);
      clear = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h77;
      @(posedge clk);
      #1;
      clear = 1'b0;
      bus.in_valid = 1'b0;
      m_last = '0;
      check("clr_busy", busy, 0);
      check("clr_in_ready", bus.in_ready, 1);
      check("clr_op_count", op_count, m_count);
      do_op(8'h10, 8'h00, 8'h09, 0, 1'b1);

      // clear coincident with the result handshake.
      do_op(8'h03, 8'hA5, 8'h0C, 0, 1'b1);
      do_op(8'h04, 8'h3C, 8'hF0, 0, 1'b0);
      @(negedge clk);
      clear = 1'b1;
      bus.res_ready = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      bus.res_ready = 1'b0;
      void'(exp_q.pop_front());
      m_last = '0;
      check("clr_hs_valid", bus.res_valid, 0);
      check("clr_hs_op_count", op_count, m_count);
      do_op(8'h10, 8'h00, 8'h21, 0, 1'b1);

      for (int i = 0; i < 40; i++) rand_op();

      // Async reset while executing.
      send_byte(8'h00);
      send_byte(8'h11);
      send_byte(8'h22);
      #2;
      rst = 1'b1;
      #1;
      check("arst_alu_a", alu_a, 0);
      check("arst_alu_b", alu_b, 0);
      check("arst_alu_op", alu_op, 0);
      check("arst_alu_go", alu_go, 0);
      check("arst_res_data", bus.res_data, 0);
      check("arst_res_flags", bus.res_flags, 0);
      check("arst_res_valid", bus.res_valid, 0);
      check("arst_op_count", op_count, 0);
      check("arst_busy", busy, 0);
      m_last  = '0;
      m_count = '0;
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("arst_in_ready", bus.in_ready, 1);
      do_op(8'h10, 8'h00, 8'h05, 0, 1'b1);

      // op_count wrap: 256 completed operations since reset.
      for (int i = 1; i < 256; i++) rand_op();
      check("op_count_wrap", op_count, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
